serial_sink: RTL

SERIAL_SINK -- requirements
Module: serial_sink

---
 rtl/serial_sink_pkg.sv | 21 ++
 rtl/serial_sink_defs.sv | 6 +
 rtl/serial_sink_rx.sv | 53 +++++
 rtl/serial_sink.sv | 77 +++++++
 4 files changed

// File: rtl/serial_sink_pkg.sv
// rtl/serial_sink_pkg.sv - types and helpers shared by the serial sink and its receiver
package serial_sink_pkg;
`include "serial_sink_defs.sv"

  localparam int WORD_W = `SIZE;
  localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_DONE
  } rx_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/serial_sink_defs.sv
// rtl/serial_sink_defs.sv - shared link constants for the serial source/sink pair
`ifndef SERIAL_SINK_DEFS_SV
`define SERIAL_SINK_DEFS_SV
`define SIZE 8
`define NUM_NODES 4
`endif

// File: rtl/serial_sink_rx.sv
// rtl/serial_sink_rx.sv - frame receiver: start bit, WORD_W data bits LSB first, one judge cycle
module serial_sink_rx
  import serial_sink_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_in,
  output logic [WORD_W-1:0] word,
  output logic              word_strobe,
  output logic              active
);

  rx_state_t         state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] shreg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (serial_in) idx <= '0;
        ST_DATA: begin
          shreg[idx] <= serial_in;
          idx        <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // The line is ignored while in DONE, so the gap bit after the data is never mistaken for a start.
  always_comb begin
    state_nxt   = state;
    word_strobe = 1'b0;
    case (state)
      ST_IDLE: if (serial_in) state_nxt = ST_DATA;
      ST_DATA: if (idx == IDX_W'(WORD_W - 1)) state_nxt = ST_DONE;
      ST_DONE: begin
        word_strobe = 1'b1;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign word   = shreg;
  assign active = (state != ST_IDLE);

endmodule

// File: rtl/serial_sink.sv
// rtl/serial_sink.sv - addressed serial sink: receiver, receive FIFO, counters and backpressure
module serial_sink
  import serial_sink_pkg::*;
#(
  parameter int NODE_ID = 0,
  parameter int DEPTH   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_in,
  output logic              busy,
  output logic [WORD_W-1:0] data_out,
  output logic              valid,
  input  logic              ack,
  output logic [15:0]       rx_count,
  output logic [7:0]        err_count
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WORD_W-1:0] rx_word;
  logic              rx_strobe;
  logic              rx_active;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic              full, push, pop;

  serial_sink_rx rx (
    .clk         (clk),
    .reset       (reset),
    .serial_in   (serial_in),
    .word        (rx_word),
    .word_strobe (rx_strobe),
    .active      (rx_active)
  );

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign valid    = (occ != '0);
  assign full     = (occ == OCC_W'(DEPTH));
  assign pop      = valid && ack;
  // A pop in the judging cycle frees the slot, so a full FIFO still accepts.
  assign push     = rx_strobe && (rx_word == WORD_W'(NODE_ID)) && (!full || pop);
  assign data_out = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      busy      <= 1'b0;
      rx_count  <= '0;
      err_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= rx_word;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop) occ <= occ + OCC_W'(1);
      else if (pop && !push) occ <= occ - OCC_W'(1);

      if (push) rx_count <= sat_inc16(rx_count);
      if (rx_strobe && !push) err_count <= sat_inc8(err_count);

      // A frame in flight counts as a slot it may claim.
      busy <= ({1'b0, occ} + (OCC_W + 1)'(rx_active)) >= (OCC_W + 1)'(DEPTH);
    end
  end

endmodule
